// File: rtl/div8su4_seq.sv
// Sequential signed-by-unsigned divider: 8-bit signed s / 4-bit unsigned u,
// one restoring step per cycle. Define DIV8SU4_EARLY_EXIT_EN to skip CALC when |s| < u.
module div8su4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] s,
  input  logic [3:0] u,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quot,
  output logic [4:0] rem,
  output logic       div0
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid holds its payload stable until then; ready never depends on valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        neg_q;
  logic [7:0]  dvd_q;
  logic [3:0]  div_q;
  logic [4:0]  pr_q;
  logic [3:0]  cnt_q;
  logic [7:0]  quot_q;
  logic [4:0]  rem_q;
  logic        out_valid_q;
  logic        div0_q;

  logic        accept;
  logic [7:0]  s_mag;
  logic [4:0]  trial;
  logic        ge;
  logic [4:0]  pr_d;
  logic [7:0]  qmag_d;
  logic [7:0]  quot_d;
  logic [4:0]  rem_d;

  assign in_ready = (state_q == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;

  // |s| as unsigned; -128 maps onto 8'h80 which reads as 128.
  assign s_mag = s[7] ? (~s + 8'd1) : s;

  // The partial remainder is always below u, so only its low 4 bits carry into the shift.
  always_comb begin
    trial  = {pr_q[3:0], dvd_q[7]};
    ge     = (trial >= {1'b0, div_q});
    pr_d   = ge ? (trial - {1'b0, div_q}) : trial;
    qmag_d = {dvd_q[6:0], ge};
    quot_d = neg_q ? (~qmag_d + 8'd1) : qmag_d;
    rem_d  = neg_q ? (~pr_d + 5'd1) : pr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      neg_q       <= 1'b0;
      dvd_q       <= 8'd0;
      div_q       <= 4'd0;
      pr_q        <= 5'd0;
      cnt_q       <= 4'd0;
      quot_q      <= 8'd0;
      rem_q       <= 5'd0;
      out_valid_q <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            neg_q <= s[7];
            dvd_q <= s_mag;
            div_q <= u;
            if (u == 4'd0) begin
              quot_q      <= 8'd0;
              rem_q       <= 5'd0;
              div0_q      <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`ifdef DIV8SU4_EARLY_EXIT_EN
            else if (s_mag < {4'd0, u}) begin
              quot_q      <= 8'd0;
              rem_q       <= s[4:0];
              div0_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`endif
            else begin
              pr_q    <= 5'd0;
              cnt_q   <= 4'd8;
              div0_q  <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          dvd_q <= qmag_d;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_div8su4_seq.sv
// Directed bench for div8su4_seq: arithmetic, latency, divide-by-zero,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_div8su4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] s;
  logic [3:0] u;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [4:0] rem;
  logic       div0;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef DIV8SU4_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div8su4_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .u(u), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div0(div0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: issue one operation, wait for the result, optionally consume it
  task automatic run_op(input logic [7:0] si, input logic [3:0] ui, input bit consume,
                        output logic [7:0] q, output logic [4:0] r, output logic d,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; s = si; u = ui;
    @(posedge clk); #1;
    in_valid = 1'b0; s = 8'h5A; u = 4'h3;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    q = quot; r = rem; d = div0;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = 8'd0; u = 4'd0;
    @(posedge clk); #1;
    vec_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || quot !== 8'd0 || rem !== 5'd0 || div0 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b quot=%h rem=%h div0=%b, required 0 0 00 00 0",
               in_ready, out_valid, quot, rem, div0);
    end
    rst_n = 1'b1; #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] sv [2];
    logic [3:0] uv [2];
    logic [7:0] qx [2];
    logic [4:0] rx [2];
    logic [7:0] q; logic [4:0] r; logic d; int lat;
    sv = '{8'd100, 8'h9C}; uv = '{4'd7, 4'd7};
    qx = '{8'h0E, 8'hF2};  rx = '{5'h02, 5'h1E};
    for (int i = 0; i < 2; i++) begin
      run_op(sv[i], uv[i], 1'b1, q, r, d, lat);
      vec_cnt++;
      if (q !== qx[i] || r !== rx[i] || d !== 1'b0 || lat != 8) begin
        err_cnt++;
        $display("FAIL basic_%0d: s=%h u=%0d got quot=%h rem=%h div0=%b lat=%0d, required quot=%h rem=%h div0=0 lat=8",
                 i, sv[i], uv[i], q, r, d, lat, qx[i], rx[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] sv [6];
    logic [3:0] uv [6];
    logic [7:0] qx [6];
    logic [4:0] rx [6];
    logic [7:0] q; logic [4:0] r; logic d; int lat; int lx;
    sv = '{8'h80, 8'd127, 8'd14,  8'hF2, 8'hFB, 8'd0};
    uv = '{4'd1,  4'd15,  4'd15,  4'd15, 4'd9,  4'd5};
    qx = '{8'h80, 8'h08,  8'h00,  8'h00, 8'h00, 8'h00};
    rx = '{5'h00, 5'h07,  5'h0E,  5'h12, 5'h1B, 5'h00};
    for (int i = 0; i < 6; i++) begin
      // vectors 2..5 have |s| < u and take the short path when enabled
      lx = (EARLY && i >= 2) ? 0 : 8;
      run_op(sv[i], uv[i], 1'b1, q, r, d, lat);
      vec_cnt++;
      if (q !== qx[i] || r !== rx[i] || d !== 1'b0 || lat != lx) begin
        err_cnt++;
        $display("FAIL boundary_%0d: s=%h u=%0d got quot=%h rem=%h div0=%b lat=%0d, required quot=%h rem=%h div0=0 lat=%0d",
                 i, sv[i], uv[i], q, r, d, lat, qx[i], rx[i], lx);
      end
    end
  endtask

  task automatic test_div0();
    logic [7:0] q; logic [4:0] r; logic d; int lat;
    run_op(8'd55, 4'd0, 1'b1, q, r, d, lat);
    vec_cnt++;
    if (q !== 8'd0 || r !== 5'd0 || d !== 1'b1 || lat != 0) begin
      err_cnt++;
      $display("FAIL div0: got quot=%h rem=%h div0=%b lat=%0d, required quot=00 rem=00 div0=1 lat=0",
               q, r, d, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q; logic [4:0] r; logic d; int lat; int bad;
    run_op(8'd100, 4'd7, 1'b0, q, r, d, lat);
    vec_cnt++;
    if (q !== 8'h0E || r !== 5'h02 || lat != 8) begin
      err_cnt++;
      $display("FAIL bp_result: quot=%h rem=%h lat=%0d, required 0e 02 8", q, r, lat);
    end
    bad = 0;
    in_valid = 1'b1; s = 8'd9; u = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== 8'h0E || rem !== 5'h02) bad++;
    end
    in_valid = 1'b0;
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL bp_no_queue: %0d cycles busy after release, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    in_valid = 1'b1; s = 8'd100; u = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || quot !== 8'd0 || rem !== 5'd0 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid: out_valid=%b quot=%h rem=%h in_ready=%b, required 0 00 00 0",
               out_valid, quot, rem, in_ready);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL reset_mid_abort: %0d cycles with result/busy, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q; logic [4:0] r; logic d; int lat;
    run_op(8'd9, 4'd3, 1'b1, q, r, d, lat);
    vec_cnt++;
    if (q !== 8'h03 || r !== 5'h00 || d !== 1'b0 || lat != 8) begin
      err_cnt++;
      $display("FAIL b2b_0: quot=%h rem=%h div0=%b lat=%0d, required 03 00 0 8", q, r, d, lat);
    end
    run_op(8'hF7, 4'd4, 1'b1, q, r, d, lat);
    vec_cnt++;
    if (q !== 8'hFE || r !== 5'h1F || d !== 1'b0 || lat != 8) begin
      err_cnt++;
      $display("FAIL b2b_1: quot=%h rem=%h div0=%b lat=%0d, required fe 1f 0 8", q, r, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div0();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
